// File: rtl/regfile_2r1w_pkg.sv
// Shared definitions for the 2-read / 1-write register file.
// Holds the array geometry, the hardwired-zero index and the clear
// sequencer state encodings. The optional write-first forwarding path is
// selected in the top-level file with the REGFILE_BYPASS_EN macro.
package regfile_2r1w_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    // True for the hardwired zero register, which is never stored or written.
    function automatic logic is_reg_zero(input logic [ADDR_W-1:0] addr);
        return (addr == REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer for regfile_2r1w.
// After a synchronous reset it walks registers 1..NREGS-1, asking the top
// to write zero to one register per cycle, and holds busy high until the
// last register has been cleared. Register 0 is not stored, so the walk
// starts at index 1. The counter carries one extra bit so the terminal
// compare never wraps.
module regfile_clear_seq
    import regfile_2r1w_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W:0] CLR_FIRST = 6'd1;
    localparam logic [ADDR_W:0] CLR_LAST  = 6'd31;

    rf_state_e         r_state;
    logic [ADDR_W:0]   r_clr_cnt;
    logic              r_busy;

    // Clear FSM: reset (re)starts the walk at index 1, READY is left only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RF_CLEAR;
            r_clr_cnt <= CLR_FIRST;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                RF_CLEAR: begin
                    if (r_clr_cnt == CLR_LAST) begin
                        r_state <= RF_READY;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= RF_CLEAR;
                        r_busy  <= 1'b1;
                    end
                    r_clr_cnt <= r_clr_cnt + 6'd1;
                end
                RF_READY: begin
                    r_state   <= RF_READY;
                    r_clr_cnt <= r_clr_cnt;
                    r_busy    <= 1'b0;
                end
                default: begin
                    r_state   <= RF_CLEAR;
                    r_clr_cnt <= CLR_FIRST;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign clr_we   = r_busy;
    assign clr_addr = r_clr_cnt[ADDR_W-1:0];

endmodule

// File: rtl/regfile_2r1w.sv
// 32x32 general-purpose register file: two combinational read ports
// (rs -> ALU a, rt -> ALU b) and one synchronous write port.
// Register 0 is hardwired to zero and is not stored. While the clear
// sequencer runs, external writes are dropped and both read ports return 0.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data to a read port addressing the register being written.
module regfile_2r1w
    import regfile_2r1w_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy
);

    logic [DATA_W-1:0] r_mem [1:NREGS-1];

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;
    logic              w_ext_we;

    regfile_clear_seq u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .busy     (w_busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    // An external write is accepted only when idle and not aimed at register 0.
    assign w_ext_we = we && !w_busy && !is_reg_zero(wr_addr);

    // Write-port mux: clear writes own the port while busy; reset blocks all writes.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = wr_addr;
        w_mem_data = wr_data;
        if (rst) begin
            w_mem_we = 1'b0;
        end else if (w_clr_we) begin
            w_mem_we   = 1'b1;
            w_mem_addr = w_clr_addr;
            w_mem_data = '0;
        end else if (w_ext_we) begin
            w_mem_we = 1'b1;
        end else begin
            w_mem_we = 1'b0;
        end
    end

    // Register array write; index 0 never reaches here.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    // Read port A: zero during clear and for register 0, otherwise the array.
    always_comb begin
        rs_data = '0;
        if (w_busy) begin
            rs_data = '0;
        end else if (is_reg_zero(rs_addr)) begin
            rs_data = '0;
`ifdef REGFILE_BYPASS_EN
        end else if (w_ext_we && (wr_addr == rs_addr)) begin
            rs_data = wr_data;
`endif
        end else begin
            rs_data = r_mem[rs_addr];
        end
    end

    // Read port B: same rules as port A.
    always_comb begin
        rt_data = '0;
        if (w_busy) begin
            rt_data = '0;
        end else if (is_reg_zero(rt_addr)) begin
            rt_data = '0;
`ifdef REGFILE_BYPASS_EN
        end else if (w_ext_we && (wr_addr == rt_addr)) begin
            rt_data = wr_data;
`endif
        end else begin
            rt_data = r_mem[rt_addr];
        end
    end

    assign busy = w_busy;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w using an expected-value queue.
module tb_regfile_2r1w;
    import regfile_2r1w_pkg::*;

    localparam int P_RS   = 0;
    localparam int P_RT   = 1;
    localparam int P_BUSY = 2;
    localparam int P_AND  = 3;
    localparam int P_SUBZ = 4;

    typedef struct {
        string       tag;
        int          port;
        logic [31:0] exp;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    regfile_2r1w dut (
        .clk     (clk),
        .rst     (rst),
        .rs_addr (rs_addr),
        .rt_addr (rt_addr),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int port, input logic [31:0] exp);
        exp_t e;
        e.tag  = tag;
        e.port = port;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t        e;
        logic [31:0] obs;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            case (e.port)
                P_RS:    obs = rs_data;
                P_RT:    obs = rt_data;
                P_BUSY:  obs = {31'd0, busy};
                P_AND:   obs = rs_data & rt_data;
                P_SUBZ:  obs = {31'd0, ((rs_data - rt_data) == 32'd0)};
                default: obs = 32'hxxxx_xxxx;
            endcase
            check_val(e.tag, obs, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        we      = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        we      = 1'b0;
    endtask

    // Counts cycles with busy high (bounded); returns the count.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        rst     = 1'b1;
        we      = 1'b0;
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        wr_addr = 5'd0;
        wr_data = 32'd0;
        tick();
        rst = 1'b0;
        push_exp("reset_busy", P_BUSY, 32'd1);
        pop_check();

        // Clear phase with a write held on reg5 the whole time.
        we      = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'hDEAD_BEEF;
        rs_addr = 5'd5;
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            if (n == 3) begin
                #1;
                push_exp("clear_rs_zero", P_RS, 32'd0);
                pop_check();
            end
            tick();
            n++;
        end
        we = 1'b0;
        check_val("busy_len_first", n, 32'd31);
        #1;
        push_exp("busy_write_ignored", P_RS, 32'd0);
        pop_check();

        // Two operands and the ALU AND of them.
        write_reg(5'd5, 32'h0F20_0603);
        write_reg(5'd6, 32'h0E24_4201);
        rs_addr = 5'd5;
        rt_addr = 5'd6;
        #1;
        push_exp("rd_reg5", P_RS, 32'h0F20_0603);
        push_exp("rd_reg6", P_RT, 32'h0E24_4201);
        push_exp("alu_and", P_AND, 32'h0E20_0201);
        pop_check();
        pop_check();
        pop_check();

        // Register 0 stays zero.
        write_reg(5'd0, 32'hFFFF_FFFF);
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        #1;
        push_exp("reg0_rs", P_RS, 32'd0);
        push_exp("reg0_rt", P_RT, 32'd0);
        pop_check();
        pop_check();

        // Same-cycle read/write of reg7.
        we      = 1'b1;
        wr_addr = 5'd7;
        wr_data = 32'hA0F2_5221;
        rs_addr = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        push_exp("same_cycle_rd", P_RS, 32'hA0F2_5221);
`else
        push_exp("same_cycle_rd", P_RS, 32'd0);
`endif
        pop_check();
        tick();
        we = 1'b0;
        #1;
        push_exp("after_edge_rd", P_RS, 32'hA0F2_5221);
        pop_check();

        // Same index on both ports, ALU SUB gives zero.
        write_reg(5'd9, 32'h80F0_4021);
        rs_addr = 5'd9;
        rt_addr = 5'd9;
        #1;
        push_exp("same_idx_rs", P_RS, 32'h80F0_4021);
        push_exp("same_idx_rt", P_RT, 32'h80F0_4021);
        push_exp("alu_sub_zero", P_SUBZ, 32'd1);
        pop_check();
        pop_check();
        pop_check();

        // Fill all registers with their index.
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), 32'(i));
        end
        rs_addr = 5'd31;
        rt_addr = 5'd1;
        #1;
        push_exp("fill_rd31", P_RS, 32'd31);
        push_exp("fill_rd1", P_RT, 32'd1);
        pop_check();
        pop_check();

        // Reset, then reset again at clear cycle 10.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
        end
        rs_addr = 5'd20;
        #1;
        push_exp("midclear_busy", P_BUSY, 32'd1);
        push_exp("midclear_rs_gated", P_RS, 32'd0);
        pop_check();
        pop_check();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy(n);
        check_val("busy_len_restart", n, 32'd31);

        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            push_exp($sformatf("cleared_rs%0d", i), P_RS, 32'd0);
            push_exp($sformatf("cleared_rt%0d", 31 - i), P_RT, 32'd0);
            pop_check();
            pop_check();
        end

        check_val("sb_leftover", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
